// File: rtl/vproc_vreg_wr_arb.sv
// Vector register file write-back arbiter: per-source FIFOs, round-robin grant,
// registered write port and pending-write mask. Optional bypass: VPROC_WR_ARB_BYPASS_EN.
module vproc_vreg_wr_arb #(
  parameter int unsigned SRC_CNT    = 4,
  parameter int unsigned MAX_PORT_W = 128,
  parameter int unsigned MAX_ADDR_W = 5,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                                        clk_i,
  input  logic                                        sync_rst_i,
  input  logic [SRC_CNT-1:0]                          src_valid_i,
  output logic [SRC_CNT-1:0]                          src_ready_o,
  input  logic [SRC_CNT-1:0][MAX_ADDR_W-1:0]          src_addr_i,
  input  logic [SRC_CNT-1:0][MAX_PORT_W-1:0]          src_data_i,
  input  logic [SRC_CNT-1:0][MAX_PORT_W/8-1:0]        src_be_i,
  output logic [MAX_ADDR_W-1:0]                       wr_addr_o,
  output logic [MAX_PORT_W-1:0]                       wr_data_o,
  output logic [MAX_PORT_W/8-1:0]                     wr_be_o,
  output logic                                        wr_we_o,
  output logic [2**MAX_ADDR_W-1:0]                    pend_o,
  output logic                                        idle_o
);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned IW = $clog2(SRC_CNT);
  localparam int unsigned BW = MAX_PORT_W / 8;

  logic [MAX_ADDR_W-1:0] r_addr [SRC_CNT][BUF_DEPTH];
  logic [MAX_PORT_W-1:0] r_data [SRC_CNT][BUF_DEPTH];
  logic [BW-1:0]         r_be   [SRC_CNT][BUF_DEPTH];
  logic [PW:0]           r_wptr [SRC_CNT];
  logic [PW:0]           r_rptr [SRC_CNT];
  logic [IW-1:0]         r_rr;
  logic                  r_we;
  logic [MAX_ADDR_W-1:0] r_waddr;
  logic [MAX_PORT_W-1:0] r_wdata;
  logic [BW-1:0]         r_wbe;

  logic [SRC_CNT-1:0]    w_empty, w_full, w_cand, w_push, w_pop;
  logic                  w_win_vld, w_win_byp;
  logic [IW-1:0]         w_win, w_idx, w_rr_nxt;
  logic [MAX_ADDR_W-1:0] w_win_addr;
  logic [MAX_PORT_W-1:0] w_win_data;
  logic [BW-1:0]         w_win_be;
  logic [PW:0]           w_slot;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int unsigned k = 0; k < SRC_CNT; k++) begin
      w_empty[k] = (r_wptr[k] == r_rptr[k]);
      w_full[k]  = (r_wptr[k][PW] != r_rptr[k][PW]) &&
                   (r_wptr[k][PW-1:0] == r_rptr[k][PW-1:0]);
    end
  end

  assign src_ready_o = ~w_full;

`ifdef VPROC_WR_ARB_BYPASS_EN
  // An empty source with an acceptable request competes as if its head were present
  assign w_cand = ~w_empty | (src_valid_i & ~w_full);
`else
  assign w_cand = ~w_empty;
`endif

  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < SRC_CNT; i++) begin
      w_idx = IW'((32'(r_rr) + i) % SRC_CNT);
      if (!w_win_vld && w_cand[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
    w_rr_nxt = (w_win == IW'(SRC_CNT - 1)) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_win_byp  = w_win_vld && w_empty[w_win];
    w_win_addr = r_addr[w_win][r_rptr[w_win][PW-1:0]];
    w_win_data = r_data[w_win][r_rptr[w_win][PW-1:0]];
    w_win_be   = r_be[w_win][r_rptr[w_win][PW-1:0]];
    if (w_win_byp) begin
      w_win_addr = src_addr_i[w_win];
      w_win_data = src_data_i[w_win];
      w_win_be   = src_be_i[w_win];
    end
  end

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned k = 0; k < SRC_CNT; k++) begin
      w_pop[k]  = w_win_vld && !w_win_byp && (w_win == IW'(k));
      w_push[k] = src_valid_i[k] && !w_full[k] && !(w_win_byp && (w_win == IW'(k)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      for (int unsigned k = 0; k < SRC_CNT; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
      r_rr    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wbe   <= '0;
    end else begin
      for (int unsigned k = 0; k < SRC_CNT; k++) begin
        if (w_push[k]) begin
          r_addr[k][r_wptr[k][PW-1:0]] <= src_addr_i[k];
          r_data[k][r_wptr[k][PW-1:0]] <= src_data_i[k];
          r_be[k][r_wptr[k][PW-1:0]]   <= src_be_i[k];
          r_wptr[k] <= r_wptr[k] + 1'b1;
        end
        if (w_pop[k]) begin
          r_rptr[k] <= r_rptr[k] + 1'b1;
        end
      end
      r_we <= w_win_vld;
      if (w_win_vld) begin
        r_waddr <= w_win_addr;
        r_wdata <= w_win_data;
        r_wbe   <= w_win_be;
        r_rr    <= w_rr_nxt;
      end
    end
  end

  // Occupied slots are those between read and write pointer; stale slots are ignored
  always_comb begin
    pend_o = '0;
    w_slot = '0;
    for (int unsigned k = 0; k < SRC_CNT; k++) begin
      for (int unsigned j = 0; j < BUF_DEPTH; j++) begin
        w_slot = r_rptr[k] + (PW+1)'(j);
        if ((PW+1)'(j) < (r_wptr[k] - r_rptr[k])) begin
          pend_o[r_addr[k][w_slot[PW-1:0]]] = 1'b1;
        end
      end
    end
    if (r_we) begin
      pend_o[r_waddr] = 1'b1;
    end
  end

  assign wr_we_o   = r_we;
  assign wr_addr_o = r_waddr;
  assign wr_data_o = r_wdata;
  assign wr_be_o   = r_wbe;
  assign idle_o    = (&w_empty) && !r_we;

endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// Scoreboard bench for vproc_vreg_wr_arb; honours VPROC_WR_ARB_BYPASS_EN like the design.
module tb_vproc_vreg_wr_arb;
  localparam int SRC = 4;
  localparam int W   = 128;
  localparam int AW  = 5;
  localparam int D   = 2;
  localparam int BW  = W / 8;
  localparam int NR  = 2 ** AW;
  localparam int EW  = AW + W + BW;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [SRC-1:0]            src_valid;
  logic [SRC-1:0]            src_ready;
  logic [SRC-1:0][AW-1:0]    src_addr;
  logic [SRC-1:0][W-1:0]     src_data;
  logic [SRC-1:0][BW-1:0]    src_be;
  logic [AW-1:0]             wr_addr;
  logic [W-1:0]              wr_data;
  logic [BW-1:0]             wr_be;
  logic                      wr_we;
  logic [NR-1:0]             pend;
  logic                      idle;

  vproc_vreg_wr_arb #(
    .SRC_CNT(SRC), .MAX_PORT_W(W), .MAX_ADDR_W(AW), .BUF_DEPTH(D)
  ) dut (
    .clk_i(clk), .sync_rst_i(rst),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_addr_i(src_addr), .src_data_i(src_data), .src_be_i(src_be),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be), .wr_we_o(wr_we),
    .pend_o(pend), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: queues per source, round-robin pointer, output register
  logic [EW-1:0] mq [SRC][$];
  logic [EW-1:0] sb [$];
  int            m_rr, m_w, m_k;
  logic          m_found, m_byp, m_we;
  logic [SRC-1:0] m_rdy;
  logic [EW-1:0] m_e;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  logic [BW-1:0] m_be;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SRC; k++) mq[k].delete();
      sb.delete();
      m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_be = '0;
    end else begin
      for (int k = 0; k < SRC; k++) m_rdy[k] = (mq[k].size() < D);
      m_found = 1'b0; m_w = 0; m_byp = 1'b0;
      for (int i = 0; i < SRC; i++) begin
        m_k = (m_rr + i) % SRC;
`ifdef VPROC_WR_ARB_BYPASS_EN
        if (!m_found && (mq[m_k].size() > 0 || (src_valid[m_k] && m_rdy[m_k]))) begin
`else
        if (!m_found && mq[m_k].size() > 0) begin
`endif
          m_found = 1'b1; m_w = m_k;
        end
      end
      if (m_found) begin
        if (mq[m_w].size() > 0) m_e = mq[m_w].pop_front();
        else begin
          m_e = {src_addr[m_w], src_data[m_w], src_be[m_w]};
          m_byp = 1'b1;
        end
        m_we = 1'b1;
        {m_addr, m_data, m_be} = m_e;
        sb.push_back(m_e);
        m_rr = (m_w + 1) % SRC;
      end else begin
        m_we = 1'b0;
      end
      for (int k = 0; k < SRC; k++)
        if (src_valid[k] && m_rdy[k] && !(m_byp && m_w == k))
          mq[k].push_back({src_addr[k], src_data[k], src_be[k]});
    end
  end

  task automatic step();
    logic [SRC-1:0] er;
    logic [NR-1:0]  ep;
    logic [EW-1:0]  e;
    logic           all_empty;
    @(posedge clk);
    @(negedge clk);
    ep = '0;
    all_empty = 1'b1;
    for (int k = 0; k < SRC; k++) begin
      er[k] = (mq[k].size() < D);
      if (mq[k].size() != 0) all_empty = 1'b0;
      for (int j = 0; j < mq[k].size(); j++) begin
        e = mq[k][j];
        ep[e[EW-1 -: AW]] = 1'b1;
      end
    end
    if (m_we) ep[m_addr] = 1'b1;
    chk("ready", 128'(src_ready), 128'(er));
    chk("pend", 128'(pend), 128'(ep));
    chk("idle", 128'(idle), 128'(all_empty && !m_we));
    chk("we", 128'(wr_we), 128'(m_we));
    if (wr_we) begin
      chk("sb_avail", 128'(sb.size() != 0), 128'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(e[EW-1 -: AW]));
        chk("wr_data", 128'(wr_data), 128'(e[BW +: W]));
        chk("wr_be", 128'(wr_be), 128'(e[BW-1:0]));
      end
    end else begin
      chk("hold_addr", 128'(wr_addr), 128'(m_addr));
      chk("hold_be", 128'(wr_be), 128'(m_be));
    end
  endtask

  task automatic clear_inputs();
    src_valid = '0;
    for (int k = 0; k < SRC; k++) begin
      src_addr[k] = '0; src_data[k] = '0; src_be[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  int        nw;
  logic      done, have_prev, started, saw_low0;
  logic [AW-1:0] prev;

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    do_reset();
    chk("rst_we", 128'(wr_we), 128'(0));
    chk("rst_pend", 128'(pend), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_ready", 128'(src_ready), 128'(4'hF));
    chk("rst_addr", 128'(wr_addr), 128'(0));

    // single write from source 1
    src_valid[1] = 1'b1; src_addr[1] = 5'd3; src_data[1] = {16{8'hA5}}; src_be[1] = '1;
    step();
    clear_inputs();
    chk("t1_pend3_a", 128'(pend[3]), 128'(1));
`ifdef VPROC_WR_ARB_BYPASS_EN
    chk("t1_we_a", 128'(wr_we), 128'(1));
    chk("t1_addr", 128'(wr_addr), 128'(3));
    step();
    chk("t1_we_b", 128'(wr_we), 128'(0));
    chk("t1_idle", 128'(idle), 128'(1));
`else
    chk("t1_we_a", 128'(wr_we), 128'(0));
    step();
    chk("t1_we_b", 128'(wr_we), 128'(1));
    chk("t1_addr", 128'(wr_addr), 128'(3));
    chk("t1_pend3_b", 128'(pend[3]), 128'(1));
    step();
    chk("t1_idle", 128'(idle), 128'(1));
    chk("t1_pend0", 128'(pend), 128'(0));
`endif

    // round-robin from pointer 0
    do_reset();
    for (int k = 0; k < SRC; k++) begin
      src_valid[k] = 1'b1; src_addr[k] = AW'(k); src_data[k] = 128'(k + 16); src_be[k] = '1;
    end
    step();
    clear_inputs();
    for (int t = 0; t < 6 && !wr_we; t++) step();
    chk("rr_start", 128'(wr_we), 128'(1));
    for (int i = 0; i < 4; i++) begin
      chk("rr_we", 128'(wr_we), 128'(1));
      chk("rr_order", 128'(wr_addr), 128'(i));
      step();
    end
    chk("rr_done", 128'(idle), 128'(1));

    // fairness between sources 0 and 2
    have_prev = 1'b0; started = 1'b0;
    for (int t = 0; t < 20; t++) begin
      src_valid = 4'b0101;
      src_addr[0] = 5'd4; src_data[0] = 128'(t);       src_be[0] = 16'h00FF;
      src_addr[2] = 5'd6; src_data[2] = 128'(t + 100); src_be[2] = 16'hFF00;
      step();
      if (started) chk("fair_b2b", 128'(wr_we), 128'(1));
      if (wr_we) begin
        if (have_prev) chk("fair_alt", 128'(wr_addr != prev), 128'(1));
        prev = wr_addr; have_prev = 1'b1; started = 1'b1;
      end
    end
    clear_inputs();
    for (int t = 0; t < 8; t++) step();

    // all sources saturating: source 0 FIFO must fill
    saw_low0 = 1'b0;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < SRC; k++) begin
        src_valid[k] = 1'b1; src_addr[k] = AW'(8 + k);
        src_data[k] = {$urandom, $urandom, $urandom, $urandom}; src_be[k] = 16'($urandom);
      end
      step();
      if (!src_ready[0]) saw_low0 = 1'b1;
    end
    chk("full_seen", 128'(saw_low0), 128'(1));
    clear_inputs();
    for (int t = 0; t < 12; t++) step();

    // reset with requests buffered
    for (int k = 0; k < 3; k++) begin
      src_valid[k] = 1'b1; src_addr[k] = AW'(20 + k); src_data[k] = 128'(k); src_be[k] = '1;
    end
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_we", 128'(wr_we), 128'(0));
    chk("mrst_pend", 128'(pend), 128'(0));
    chk("mrst_ready", 128'(src_ready), 128'(4'hF));
    chk("mrst_idle", 128'(idle), 128'(1));
    for (int t = 0; t < 6; t++) begin
      step();
      chk("mrst_no_stale", 128'(wr_we), 128'(0));
    end

    // duplicate address from one source
    nw = 0;
    src_valid[0] = 1'b1; src_addr[0] = 5'd7; src_data[0] = 128'h11; src_be[0] = '1;
    step();
    if (wr_we && wr_addr == 5'd7) nw++;
    src_data[0] = 128'h22;
    step();
    if (wr_we && wr_addr == 5'd7) nw++;
    clear_inputs();
    done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      if (nw == 2) begin
        chk("dup_pend_hi", 128'(pend[7]), 128'(1));
        step();
        chk("dup_pend_lo", 128'(pend[7]), 128'(0));
        done = 1'b1;
      end else begin
        step();
        if (wr_we && wr_addr == 5'd7) nw++;
      end
    end
    chk("dup_seen", 128'(nw), 128'(2));

    // random traffic, including zero byte enables
    for (int t = 0; t < 200; t++) begin
      src_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < SRC; k++) begin
        src_addr[k] = AW'($urandom);
        src_data[k] = {$urandom, $urandom, $urandom, $urandom};
        src_be[k]   = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom);
      end
      step();
    end
    clear_inputs();
    for (int t = 0; t < 12; t++) step();
    chk("sb_drain", 128'(sb.size()), 128'(0));
    chk("idle_end", 128'(idle), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
